// File: rtl/uop_issue_queue_if.sv
// uop_issue_queue_if: bundle intake and uop issue handshakes.
// master offers bundles and takes uops; slave is the queue.
interface uop_issue_queue_if #(
   parameter int UOP_W    = 20,
   parameter int MAX_UOPS = 3,
   parameter int CNT_W    = 2
);
   logic                      in_valid;
   logic                      in_ready;
   logic [MAX_UOPS*UOP_W-1:0] in_uops;
   logic [CNT_W-1:0]          in_count;
   logic                      out_valid;
   logic                      out_ready;
   logic [UOP_W-1:0]          out_uop;
   logic                      out_last;

   modport master (
      output in_valid, in_uops, in_count, out_ready,
      input  in_ready, out_valid, out_uop, out_last
   );

   modport slave (
      input  in_valid, in_uops, in_count, out_ready,
      output in_ready, out_valid, out_uop, out_last
   );
endinterface

// File: rtl/uop_issue_queue.sv
// uop_issue_queue: bundle FIFO, uop sequencer and flag scoreboard.
// Issues one uop per cycle, highest index first.
module uop_issue_queue #(
   parameter int UOP_W    = 20,
   parameter int MAX_UOPS = 3,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = 2,
   parameter int WF_BIT   = 12,
   parameter int RF_BIT   = 15,
   parameter int MAX_PEND = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hold,
   input  logic                     flush,
   input  logic                     sf_written,
   output logic                     sf_busy,
   output logic [$clog2(DEPTH):0]   level,
   uop_issue_queue_if.slave         bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(MAX_PEND + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_UOPS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PW-1:0]    PEND_MAX = PW'(MAX_PEND);
   localparam logic [PW-1:0]    PEND_ONE = PW'(1);
   localparam logic [AW:0]      LVL_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]      LVL_ONE  = (AW + 1)'(1);

   logic [MAX_UOPS*UOP_W-1:0] mem_uops [DEPTH];
   logic [CNT_W-1:0]          mem_cnt  [DEPTH];

   logic [AW:0]               wr_ptr;
   logic [AW:0]               rd_ptr;
   logic [AW:0]               rd_ptr_nx;
   logic [CNT_W-1:0]          idx;
   logic [CNT_W-1:0]          idx_nxt;
   logic [CNT_W-1:0]          in_cnt_c;
   logic [PW-1:0]             pend;
   logic [MAX_UOPS*UOP_W-1:0] head_bundle;
   logic [UOP_W-1:0]          head_uop;
   logic                      nonempty;
   logic                      full;
   logic                      stall;
   logic                      fire;
   logic                      push;
   logic                      pop;
   logic                      act_flush;
   logic                      inc;
   logic                      dec;

   assign level     = wr_ptr - rd_ptr;
   assign nonempty  = (level != '0);
   assign full      = (level == LVL_FULL);
   assign rd_ptr_nx = rd_ptr + LVL_ONE;
   assign in_cnt_c  = (bus.in_count > CNT_MAX) ? CNT_MAX : bus.in_count;

   assign head_bundle = mem_uops[rd_ptr[AW-1:0]];

   // Select the head uop addressed by the sequencer index.
   always_comb begin
      head_uop = '0;
      for (int i = 0; i < MAX_UOPS; i++) begin
         if (idx == CNT_W'(i)) head_uop = head_bundle[i*UOP_W +: UOP_W];
      end
   end

   assign bus.out_uop  = nonempty ? head_uop : '0;
   assign bus.out_last = nonempty & (idx == '0);

   assign stall = (bus.out_uop[RF_BIT] & (pend != '0)) |
                  (bus.out_uop[WF_BIT] & (pend == PEND_MAX));

   assign bus.out_valid = nonempty & ~flush & ~stall;
   assign bus.in_ready  = ~full & ~hold & ~flush;

   assign act_flush = flush & ~hold;
   assign fire      = bus.out_valid & bus.out_ready & ~hold;
   assign pop       = fire & (idx == '0);
   assign push      = bus.in_valid & bus.in_ready;

   assign inc     = fire & bus.out_uop[WF_BIT];
   assign dec     = sf_written & (pend != '0);
   assign sf_busy = (pend != '0);

   // Next sequencer index: reload on a new head, else count down.
   always_comb begin
      idx_nxt = idx;
      if (act_flush) begin
         idx_nxt = '0;
      end else if (pop) begin
         if (level > LVL_ONE) idx_nxt = mem_cnt[rd_ptr_nx[AW-1:0]];
         else if (push)       idx_nxt = in_cnt_c;
         else                 idx_nxt = '0;
      end else if (fire) begin
         idx_nxt = idx - CNT_ONE;
      end else if (push && !nonempty) begin
         idx_nxt = in_cnt_c;
      end
   end

   // Pointer and sequencer state; flush empties, hold freezes.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         idx    <= '0;
      end else if (act_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         idx    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + LVL_ONE;
         if (pop)  rd_ptr <= rd_ptr_nx;
         idx <= idx_nxt;
      end
   end

   // Bundle storage, written on accept with the clamped count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_uops[wr_ptr[AW-1:0]] <= bus.in_uops;
         mem_cnt[wr_ptr[AW-1:0]]  <= in_cnt_c;
      end
   end

   // Outstanding flag writes; keeps counting through hold and flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
      end else if (inc && !dec) begin
         pend <= pend + PEND_ONE;
      end else if (dec && !inc) begin
         pend <= pend - PEND_ONE;
      end
   end
endmodule

// File: tb/tb_uop_issue_queue.sv
// tb_uop_issue_queue: queue-level model checked every cycle,
// plus directed scenarios with literal issue-order checks.
module tb_uop_issue_queue;
   localparam int UOP_W    = 20;
   localparam int MAX_UOPS = 3;
   localparam int DEPTH    = 4;
   localparam int CNT_W    = 2;
   localparam int WF_BIT   = 12;
   localparam int RF_BIT   = 15;
   localparam int MAX_PEND = 3;
   localparam int LW       = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          hold = 1'b0;
   logic          flush = 1'b0;
   logic          sf_written = 1'b0;
   logic          sf_busy;
   logic [LW-1:0] level;

   uop_issue_queue_if #(
      .UOP_W(UOP_W), .MAX_UOPS(MAX_UOPS), .CNT_W(CNT_W)
   ) bus ();

   uop_issue_queue #(
      .UOP_W(UOP_W), .MAX_UOPS(MAX_UOPS), .DEPTH(DEPTH),
      .CNT_W(CNT_W), .WF_BIT(WF_BIT), .RF_BIT(RF_BIT),
      .MAX_PEND(MAX_PEND)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hold(hold),
      .flush(flush),
      .sf_written(sf_written),
      .sf_busy(sf_busy),
      .level(level),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [UOP_W-1:0] uop;
      bit               last;
   } ent_t;

   ent_t             mq[$];
   int               mpend = 0;
   bit               armed = 0;
   logic [UOP_W-1:0] flog[$];
   bit               llog[$];
   logic [UOP_W-1:0] exp_q[$];
   bit               exp_l[$];
   int               total = 0;
   int               bad = 0;

   int               m_lvl;
   int               m_cnt;
   bit               m_ne;
   bit               m_last;
   bit               m_valid;
   bit               m_rdy;
   bit               m_stall;
   bit               m_fire;
   bit               m_dec;
   logic [UOP_W-1:0] m_uop;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a flat queue of uops in issue order plus a pending count.
   always @(negedge clk) begin
      if (rst) begin
         mq.delete();
         mpend = 0;
         armed = 1;
      end else if (armed) begin
         m_lvl = 0;
         foreach (mq[i]) if (mq[i].last) m_lvl++;
         m_ne    = (mq.size() != 0);
         m_uop   = m_ne ? mq[0].uop : '0;
         m_last  = m_ne && mq[0].last;
         m_stall = (m_uop[RF_BIT] && mpend != 0) ||
                   (m_uop[WF_BIT] && mpend == MAX_PEND);
         m_valid = m_ne && !flush && !m_stall;
         m_rdy   = (m_lvl != DEPTH) && !hold && !flush;

         chk("out_valid", bus.out_valid, m_valid);
         chk("out_uop", bus.out_uop, m_uop);
         chk("out_last", bus.out_last, m_last);
         chk("in_ready", bus.in_ready, m_rdy);
         chk("level", level, m_lvl);
         chk("sf_busy", sf_busy, mpend != 0);

         if (bus.out_valid && bus.out_ready && !hold) begin
            flog.push_back(bus.out_uop);
            llog.push_back(bus.out_last);
         end

         m_fire = m_valid && bus.out_ready && !hold;
         m_dec  = sf_written && (mpend > 0);
         if (m_fire && m_uop[WF_BIT]) mpend++;
         if (m_dec) mpend--;

         if (!hold) begin
            if (flush) begin
               mq.delete();
            end else begin
               if (m_fire) void'(mq.pop_front());
               if (bus.in_valid && m_rdy) begin
                  m_cnt = int'(bus.in_count);
                  if (m_cnt > MAX_UOPS - 1) m_cnt = MAX_UOPS - 1;
                  for (int i = m_cnt; i >= 0; i--)
                     mq.push_back('{uop: bus.in_uops[i*UOP_W +: UOP_W],
                                    last: (i == 0)});
               end
            end
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic push(input logic [CNT_W-1:0] c,
                       input logic [UOP_W-1:0] u2,
                       input logic [UOP_W-1:0] u1,
                       input logic [UOP_W-1:0] u0);
      bit acc = 0;
      bus.in_valid = 1'b1;
      bus.in_count = c;
      bus.in_uops  = {u2, u1, u0};
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      chk("push_accept", acc, 1);
   endtask

   task automatic drain();
      bit done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         done = (level == '0);
      end
      chk("drain", done, 1);
      step();
   endtask

   task automatic check_log(string tag);
      chk({tag, "_n"}, flog.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < flog.size(); i++) begin
         chk($sformatf("%s_uop%0d", tag, i), flog[i], exp_q[i]);
         chk($sformatf("%s_last%0d", tag, i), llog[i], exp_l[i]);
      end
      flog.delete();
      llog.delete();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_uops   = '0;
      bus.in_count  = '0;
      bus.out_ready = 1'b0;
      step(2);
      rst = 1'b0;

      at_neg();
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_last", bus.out_last, 0);
      chk("rst_uop", bus.out_uop, 0);
      chk("rst_busy", sf_busy, 0);
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_level", level, 0);
      step();

      // basic issue order across three bundles
      flog.delete();
      llog.delete();
      bus.out_ready = 1'b1;
      push(2'd2, 20'h000A2, 20'h000A1, 20'h000A0);
      at_neg();
      chk("t1_first_valid", bus.out_valid, 1);
      chk("t1_first_uop", bus.out_uop, 20'h000A2);
      step();
      push(2'd0, 20'h0, 20'h0, 20'h000B0);
      push(2'd1, 20'h0, 20'h000C1, 20'h000C0);
      drain();
      exp_q = '{20'h000A2, 20'h000A1, 20'h000A0,
                20'h000B0, 20'h000C1, 20'h000C0};
      exp_l = '{0, 0, 1, 1, 0, 1};
      check_log("t1");

      // fill to DEPTH, refuse a fifth, reopen after one pop
      bus.out_ready = 1'b0;
      push(2'd0, 20'h0, 20'h0, 20'h000D0);
      push(2'd0, 20'h0, 20'h0, 20'h000E0);
      push(2'd0, 20'h0, 20'h0, 20'h000F0);
      push(2'd0, 20'h0, 20'h0, 20'h00010);
      at_neg();
      chk("t2_level_full", level, 4);
      chk("t2_ready_full", bus.in_ready, 0);
      step();
      bus.in_valid = 1'b1;
      bus.in_count = 2'd0;
      bus.in_uops  = {20'h0, 20'h0, 20'h00020};
      step();
      at_neg();
      chk("t2_fifth_ready", bus.in_ready, 0);
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      at_neg();
      chk("t2_level_after_pop", level, 3);
      chk("t2_ready_after_pop", bus.in_ready, 1);
      step();
      drain();
      exp_q = '{20'h000D0, 20'h000E0, 20'h000F0, 20'h00010};
      exp_l = '{1, 1, 1, 1};
      check_log("t2");

      // flag reader waits for an outstanding writer
      push(2'd1, 20'h0, 20'h01001, 20'h08002);
      step();
      for (int k = 0; k < 5; k++) begin
         at_neg();
         chk("t3_stall_valid", bus.out_valid, 0);
         chk("t3_stall_busy", sf_busy, 1);
         chk("t3_stall_uop", bus.out_uop, 20'h08002);
         step();
      end
      sf_written = 1'b1;
      step();
      sf_written = 1'b0;
      at_neg();
      chk("t3_release_valid", bus.out_valid, 1);
      chk("t3_release_busy", sf_busy, 0);
      step();
      drain();
      exp_q = '{20'h01001, 20'h08002};
      exp_l = '{0, 1};
      check_log("t3");

      // writer saturation, simultaneous inc/dec, no underflow
      push(2'd2, 20'h011A2, 20'h011A1, 20'h011A0);
      push(2'd1, 20'h0, 20'h011B1, 20'h000B0);
      step(2);
      at_neg();
      chk("t4_sat_valid", bus.out_valid, 0);
      chk("t4_sat_uop", bus.out_uop, 20'h011B1);
      chk("t4_sat_busy", sf_busy, 1);
      step();
      sf_written = 1'b1;
      step();
      at_neg();
      chk("t4_writer_valid", bus.out_valid, 1);
      step();
      sf_written = 1'b0;
      at_neg();
      chk("t4_plain_uop", bus.out_uop, 20'h000B0);
      chk("t4_plain_valid", bus.out_valid, 1);
      chk("t4_plain_busy", sf_busy, 1);
      step();
      sf_written = 1'b1;
      step(2);
      at_neg();
      chk("t4_cleared_busy", sf_busy, 0);
      step();
      sf_written = 1'b0;
      at_neg();
      chk("t4_no_underflow", sf_busy, 0);
      step();
      push(2'd1, 20'h0, 20'h011C1, 20'h080C0);
      step();
      at_neg();
      chk("t4_reader_stall", bus.out_valid, 0);
      chk("t4_reader_busy", sf_busy, 1);
      step();
      sf_written = 1'b1;
      step();
      sf_written = 1'b0;
      drain();
      exp_q = '{20'h011A2, 20'h011A1, 20'h011A0,
                20'h011B1, 20'h000B0, 20'h011C1, 20'h080C0};
      exp_l = '{0, 0, 1, 0, 1, 0, 1};
      check_log("t4");

      // flush mid-bundle drops queue and offered bundle
      bus.out_ready = 1'b0;
      push(2'd2, 20'h011D2, 20'h000D1, 20'h000D0);
      push(2'd0, 20'h0, 20'h0, 20'h000E0);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_count = 2'd0;
      bus.in_uops  = {20'h0, 20'h0, 20'h000F5};
      at_neg();
      chk("t5_flush_ready", bus.in_ready, 0);
      chk("t5_flush_valid", bus.out_valid, 0);
      step();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      at_neg();
      chk("t5_level", level, 0);
      chk("t5_valid", bus.out_valid, 0);
      chk("t5_busy_kept", sf_busy, 1);
      step(2);
      at_neg();
      chk("t5_level_later", level, 0);
      step();
      sf_written = 1'b1;
      step();
      sf_written = 1'b0;
      exp_q = '{20'h011D2};
      exp_l = '{0};
      check_log("t5");

      // hold at idx 1 freezes issue, scoreboard still retires
      push(2'd2, 20'h01112, 20'h00111, 20'h00110);
      push(2'd0, 20'h0, 20'h0, 20'h00120);
      bus.out_ready = 1'b1;
      step();
      hold = 1'b1;
      at_neg();
      chk("t6_hold_uop", bus.out_uop, 20'h00111);
      chk("t6_hold_level", level, 2);
      step();
      sf_written = 1'b1;
      at_neg();
      chk("t6_hold_level2", level, 2);
      step();
      sf_written = 1'b0;
      at_neg();
      chk("t6_hold_busy", sf_busy, 0);
      step();
      hold = 1'b0;
      at_neg();
      chk("t6_resume_uop", bus.out_uop, 20'h00111);
      chk("t6_resume_valid", bus.out_valid, 1);
      step();
      drain();
      exp_q = '{20'h01112, 20'h00111, 20'h00110, 20'h00120};
      exp_l = '{0, 0, 1, 1};
      check_log("t6");

      // oversize count clamps; reset mid-bundle abandons it
      push(2'd3, 20'h000F2, 20'h000F1, 20'h000F0);
      drain();
      exp_q = '{20'h000F2, 20'h000F1, 20'h000F0};
      exp_l = '{0, 0, 1};
      check_log("t7");
      bus.out_ready = 1'b0;
      push(2'd2, 20'h000A2, 20'h000A1, 20'h000A0);
      bus.out_ready = 1'b1;
      step();
      rst = 1'b1;
      bus.out_ready = 1'b0;
      step();
      rst = 1'b0;
      at_neg();
      chk("t7_rst_level", level, 0);
      chk("t7_rst_valid", bus.out_valid, 0);
      chk("t7_rst_last", bus.out_last, 0);
      chk("t7_rst_uop", bus.out_uop, 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
